// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: synchronized/debounced buttons driving an IDLE/RUN/PAUSE(/LAP) FSM.
// The LAP state and lap register exist only when STOPWATCH_LAP_EN is defined.

module stopwatch_debounce #(
    parameter int CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic evt
);
    localparam int CW = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          blocked_q, blocked_d;
    logic          evt_q, evt_d;
    logic          sample;

    assign sample = sync_q[1];

    // After reset the button must be seen released for a full debounce window
    // before any press is accepted, so a button held through reset stays silent.
    always_comb begin
        sync_d    = {sync_q[0], btn_raw};
        cnt_d     = '0;
        level_d   = level_q;
        blocked_d = blocked_q;
        evt_d     = 1'b0;
        if (blocked_q) begin
            if (!sample) begin
                if (cnt_q == LAST) blocked_d = 1'b0;
                else               cnt_d = cnt_q + CW'(1);
            end
        end else if (sample != level_q) begin
            if (cnt_q == LAST) begin
                level_d = sample;
                evt_d   = sample;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= '0;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            blocked_q <= 1'b1;
            evt_q     <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            blocked_q <= blocked_d;
            evt_q     <= evt_d;
        end
    end

    assign evt = evt_q;
endmodule

module stopwatch_ctrl #(
    parameter int          DEBOUNCE_CYCLES = 1000000,
    parameter logic [7:0]  STOP_AT         = 8'h99
) (
    input  logic       clk,
    input  logic       init_regs,
    input  logic       btn_start,
    input  logic       btn_lap,
    input  logic       btn_clear,
    input  logic [7:0] time_reading,
    output logic       count_enabled,
    output logic       counter_clear,
    output logic [7:0] display_value,
    output logic       led_running
);
`ifdef STOPWATCH_LAP_EN
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_LAP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;
`endif

    logic [2:0] btn_raw, evt;
    logic       start_evt, clear_evt;

    assign btn_raw   = {btn_lap, btn_clear, btn_start};
    assign start_evt = evt[0];
    assign clear_evt = evt[1];

    stopwatch_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db [2:0] (
        .clk     (clk),
        .rst     (init_regs),
        .btn_raw (btn_raw),
        .evt     (evt)
    );

    state_t     state_q, state_d;
    logic       run_q, running_d;
    logic       clr_q, clr_d;
    logic [7:0] disp_q, disp_d;
    logic       active;

`ifdef STOPWATCH_LAP_EN
    logic       lap_evt;
    logic [7:0] lap_q, lap_d;
    assign lap_evt = evt[2];
    assign active  = (state_q == S_RUN) || (state_q == S_LAP);
`else
    logic unused_lap_evt;
    assign unused_lap_evt = evt[2];
    assign active         = (state_q == S_RUN);
`endif

    // Clear only matters in PAUSE, where it is checked ahead of start.
    always_comb begin
        state_d = state_q;
        clr_d   = 1'b0;
`ifdef STOPWATCH_LAP_EN
        lap_d   = lap_q;
`endif
        case (state_q)
            S_IDLE:  if (start_evt) state_d = S_RUN;
            S_RUN: begin
                if (start_evt) state_d = S_PAUSE;
`ifdef STOPWATCH_LAP_EN
                else if (lap_evt) begin
                    state_d = S_LAP;
                    lap_d   = time_reading;
                end
`endif
            end
            S_PAUSE: begin
                if (clear_evt) begin
                    state_d = S_IDLE;
                    clr_d   = 1'b1;
                end else if (start_evt) begin
                    state_d = S_RUN;
                end
            end
`ifdef STOPWATCH_LAP_EN
            S_LAP: begin
                if (start_evt)    state_d = S_PAUSE;
                else if (lap_evt) state_d = S_RUN;
            end
`endif
            default: state_d = S_IDLE;
        endcase

        if (active && time_reading == STOP_AT) begin
            state_d = S_PAUSE;
`ifdef STOPWATCH_LAP_EN
            lap_d   = lap_q;
`endif
        end

`ifdef STOPWATCH_LAP_EN
        running_d = (state_d == S_RUN) || (state_d == S_LAP);
        disp_d    = (state_d == S_LAP) ? lap_d : time_reading;
`else
        running_d = (state_d == S_RUN);
        disp_d    = time_reading;
`endif
    end

    always_ff @(posedge clk) begin
        if (init_regs) begin
            state_q <= S_IDLE;
            run_q   <= 1'b0;
            clr_q   <= 1'b1;
            disp_q  <= 8'h00;
`ifdef STOPWATCH_LAP_EN
            lap_q   <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            run_q   <= running_d;
            clr_q   <= clr_d;
            disp_q  <= disp_d;
`ifdef STOPWATCH_LAP_EN
            lap_q   <= lap_d;
`endif
        end
    end

    assign count_enabled = run_q;
    assign led_running   = run_q;
    assign counter_clear = clr_q;
    assign display_value = disp_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them.

module tb_stopwatch_ctrl;
    localparam int         DB   = 4;
    localparam logic [7:0] STOP = 8'h05;
`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       init_regs = 1'b1;
    logic       btn_start = 1'b0, btn_lap = 1'b0, btn_clear = 1'b0;
    logic [7:0] time_reading = 8'h00;
    logic       count_enabled, counter_clear, led_running;
    logic [7:0] display_value;

    stopwatch_ctrl #(.DEBOUNCE_CYCLES(DB), .STOP_AT(STOP)) dut (
        .clk           (clk),
        .init_regs     (init_regs),
        .btn_start     (btn_start),
        .btn_lap       (btn_lap),
        .btn_clear     (btn_clear),
        .time_reading  (time_reading),
        .count_enabled (count_enabled),
        .counter_clear (counter_clear),
        .display_value (display_value),
        .led_running   (led_running)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic       ce;
        logic       clr;
        logic [7:0] disp;
        logic       led;
        string      name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].at <= cyc) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (e.at != cyc ||
                {count_enabled, counter_clear, display_value, led_running} !=
                {e.ce, e.clr, e.disp, e.led}) begin
                errors++;
                $display("FAIL %s @cyc %0d (due %0d): got ce=%b clr=%b disp=%h led=%b, want ce=%b clr=%b disp=%h led=%b",
                         e.name, cyc, e.at, count_enabled, counter_clear, display_value, led_running,
                         e.ce, e.clr, e.disp, e.led);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int dly, input logic ce, input logic clr,
                            input logic [7:0] disp, input logic led, input string nm);
        exp_t e;
        e.at = cyc + dly; e.ce = ce; e.clr = clr; e.disp = disp; e.led = led; e.name = nm;
        q.push_back(e);
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0: btn_start = v;
            1: btn_clear = v;
            default: btn_lap = v;
        endcase
    endtask

    // Press, hold long enough to debounce, release and let the release settle.
    task automatic tap(input int b);
        set_btn(b, 1'b1);
        step(10);
        set_btn(b, 1'b0);
        step(8);
    endtask

    initial begin
        // Reset and release
        step(1);
        push_exp(0, 0, 1, 8'h00, 0, "in_reset");
        step(2);
        init_regs = 1'b0;
        step(1);
        push_exp(0, 0, 0, 8'h00, 0, "post_reset");
        step(6);

        // Start press from IDLE: event lands 7 cycles after the raw press
        push_exp(6, 0, 0, 8'h00, 0, "pre_run");
        push_exp(7, 1, 0, 8'h00, 1, "run");
        tap(0);

        // Lap capture and release
        time_reading = 8'h03;
        step(2);
        push_exp(0, 1, 0, 8'h03, 1, "run_disp03");
        push_exp(7, 1, 0, 8'h03, 1, "lap_enter");
        tap(2);
        time_reading = 8'h04;
        step(1);
        push_exp(0, 1, 0, LAP_EN ? 8'h03 : 8'h04, 1, "lap_hold");
        step(2);
        push_exp(0, 1, 0, LAP_EN ? 8'h03 : 8'h04, 1, "lap_hold2");
        push_exp(6, 1, 0, LAP_EN ? 8'h03 : 8'h04, 1, "lap_exit_pre");
        push_exp(7, 1, 0, 8'h04, 1, "lap_exit_live");
        tap(2);

        // RUN -> PAUSE -> clear -> IDLE
        push_exp(6, 1, 0, 8'h04, 1, "pause_pre");
        push_exp(7, 0, 0, 8'h04, 0, "pause");
        tap(0);
        push_exp(6, 0, 0, 8'h04, 0, "clr_pre");
        push_exp(7, 0, 1, 8'h04, 0, "clr_pulse");
        push_exp(8, 0, 0, 8'h04, 0, "clr_end");
        tap(1);

        // IDLE -> RUN -> PAUSE, then start+clear together
        push_exp(7, 1, 0, 8'h04, 1, "run2");
        tap(0);
        push_exp(7, 0, 0, 8'h04, 0, "pause2");
        tap(0);
        btn_start = 1'b1; btn_clear = 1'b1;
        push_exp(6, 0, 0, 8'h04, 0, "both_pre");
        push_exp(7, 0, 1, 8'h04, 0, "both_clr");
        push_exp(8, 0, 0, 8'h04, 0, "both_end");
        push_exp(10, 0, 0, 8'h04, 0, "both_no_run");
        step(10);
        btn_start = 1'b0; btn_clear = 1'b0;
        step(8);

        // 3-cycle bounce in IDLE must not start
        btn_start = 1'b1;
        push_exp(8, 0, 0, 8'h04, 0, "bounce_a");
        push_exp(12, 0, 0, 8'h04, 0, "bounce_b");
        step(3);
        btn_start = 1'b0;
        step(12);

        // Auto-stop at STOP_AT
        push_exp(7, 1, 0, 8'h04, 1, "run3");
        tap(0);
        push_exp(0, 1, 0, 8'h04, 1, "pre_stop");
        time_reading = STOP;
        step(1);
        push_exp(0, 0, 0, 8'h05, 0, "autostop");
        step(1);
        push_exp(0, 0, 0, 8'h05, 0, "autostop_hold");
        time_reading = 8'h03;
        step(2);

        // Reset while in LAP (RUN without the feature) with start held
        push_exp(7, 1, 0, 8'h03, 1, "run4");
        tap(0);
        push_exp(7, 1, 0, 8'h03, 1, "lap2");
        tap(2);
        btn_start = 1'b1;
        step(2);
        init_regs = 1'b1;
        step(1);
        push_exp(0, 0, 1, 8'h00, 0, "rst_mid");
        step(2);
        init_regs = 1'b0;
        step(1);
        push_exp(0, 0, 0, 8'h03, 0, "rst_rel");
        step(15);
        push_exp(0, 0, 0, 8'h03, 0, "held_no_evt");
        btn_start = 1'b0;
        step(8);
        push_exp(0, 0, 0, 8'h03, 0, "released_idle");
        push_exp(7, 1, 0, 8'h03, 1, "repress_run");
        tap(0);

        for (int i = 0; i < 50 && q.size() > 0; i++) step(1);
        if (q.size() > 0) begin
            $display("FAIL drain: %0d expectations never checked, want 0", q.size());
            errors += q.size();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
